mult_datapath: RTL and testbench

Register/arithmetic datapath for the 8-bit signed add-shift multiplier, sitting directly downstream of the multiplier control FSM. It holds the multiplicand S, the accumulator A, the multiplier/low product B and the sign-extension bit X. It applies the FSM's Load/Subtract/Shift_En/A_CLR strobes each cycle, and returns A and M = B[0] to the FSM. After eight add/shift steps the 16-bit two's-complement product sits in {A, B}.

---
 rtl/mult_datapath_if.sv | 24 ++
 rtl/mult_datapath.sv | 69 ++++++
 tb/tb_mult_datapath.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Strobe/result bundle between the multiplier control FSM (master) and the datapath (slave).
interface mult_datapath_if;
    logic       LoadB;
    logic       A_CLR;
    logic       Load;
    logic       Subtract;
    logic       Shift_En;
    logic [7:0] Din;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       M;
    logic       Done;

    modport master (
        output LoadB, A_CLR, Load, Subtract, Shift_En, Din,
        input  Aval, Bval, X, M, Done
    );

    modport slave (
        input  LoadB, A_CLR, Load, Subtract, Shift_En, Din,
        output Aval, Bval, X, M, Done
    );
endinterface

// File: rtl/mult_datapath.sv
// S/A/B/X register datapath for the 8-bit signed add-shift multiplier.
// Define MULT_STEP_COUNT_EN to build the step counter and Done flag; otherwise Done is tied low.
module mult_datapath (
    input logic            Clk,
    input logic            Reset,
    mult_datapath_if.slave bus
);
    logic [7:0] s_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       x_reg;
    logic [8:0] sum;

    // Nine-bit sign-extended add keeps the product exact; with no add the old {X,A} passes through.
    always_comb begin
        sum = {x_reg, a_reg};
        if (bus.Load && b_reg[0]) begin
            if (bus.Subtract)
                sum = {a_reg[7], a_reg} + ~{s_reg[7], s_reg} + 9'd1;
            else
                sum = {a_reg[7], a_reg} + {s_reg[7], s_reg};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_reg <= 8'h00;
            a_reg <= 8'h00;
            b_reg <= 8'h00;
            x_reg <= 1'b0;
        end else if (bus.LoadB) begin
            b_reg <= bus.Din;
            a_reg <= 8'h00;
            x_reg <= 1'b0;
        end else if (bus.A_CLR) begin
            s_reg <= bus.Din;
            a_reg <= 8'h00;
            x_reg <= 1'b0;
        end else if (bus.Shift_En) begin
            // Shifting the post-add value covers both plain shifts and the combined add/shift step.
            x_reg <= sum[8];
            a_reg <= {sum[8], sum[7:1]};
            b_reg <= {sum[0], b_reg[7:1]};
        end else if (bus.Load) begin
            x_reg <= sum[8];
            a_reg <= sum[7:0];
        end
    end

`ifdef MULT_STEP_COUNT_EN
    logic [3:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset || bus.LoadB || bus.A_CLR)
            cnt <= 4'd0;
        else if (bus.Shift_En && cnt != 4'd8)
            cnt <= cnt + 4'd1;
    end

    assign bus.Done = (cnt == 4'd8);
`else
    assign bus.Done = 1'b0;
`endif

    assign bus.Aval = a_reg;
    assign bus.Bval = b_reg;
    assign bus.X    = x_reg;
    assign bus.M    = b_reg[0];
endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed spec vectors plus random signed products
// compared against plain signed arithmetic.
module tb_mult_datapath;
    logic Clk;
    logic Reset;
    int   tests_run;
    int   tests_failed;

`ifdef MULT_STEP_COUNT_EN
    localparam bit DONE_EN = 1'b1;
`else
    localparam bit DONE_EN = 1'b0;
`endif

    mult_datapath_if bus ();

    mult_datapath dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clock of strobes; outputs are stable and readable on return.
    task automatic applyStimulus(input logic rst, input logic lb, input logic ac, input logic ld,
                                 input logic sub, input logic sh, input logic [7:0] din);
        Reset        = rst;
        bus.LoadB    = lb;
        bus.A_CLR    = ac;
        bus.Load     = ld;
        bus.Subtract = sub;
        bus.Shift_En = sh;
        bus.Din      = din;
        @(posedge Clk);
        #1;
        Reset        = 1'b0;
        bus.LoadB    = 1'b0;
        bus.A_CLR    = 1'b0;
        bus.Load     = 1'b0;
        bus.Subtract = 1'b0;
        bus.Shift_En = 1'b0;
    endtask

    // Eight combined add/shift steps, the last one subtracting (sign bit of the multiplier).
    task automatic runSteps(input logic [7:0] din);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, (i == 7), 1'b1, din);
    endtask

    task automatic checkProduct(input string name, input logic [15:0] p, input logic done_exp);
        tests_run++;
        if ({bus.Aval, bus.Bval} !== p) begin
            tests_failed++;
            $display("[TB] FAIL %s product: got %h expected %h", name, {bus.Aval, bus.Bval}, p);
        end
        tests_run++;
        if (bus.X !== p[15]) begin
            tests_failed++;
            $display("[TB] FAIL %s X: got %b expected %b", name, bus.X, p[15]);
        end
        tests_run++;
        if (bus.M !== p[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s M: got %b expected %b", name, bus.M, p[0]);
        end
        tests_run++;
        if (bus.Done !== (DONE_EN & done_exp)) begin
            tests_failed++;
            $display("[TB] FAIL %s Done: got %b expected %b", name, bus.Done, DONE_EN & done_exp);
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkProduct("reset", 16'h0000, 1'b0);
    endtask

    task automatic test_directed();
        logic [7:0]  bv [3] = '{8'hFD, 8'h80, 8'hFF};
        logic [7:0]  sv [3] = '{8'h07, 8'h80, 8'hFF};
        logic [15:0] pv [3] = '{16'hFFEB, 16'h4000, 16'h0001};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bv[i]);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, sv[i]);
            runSteps(8'h00);
            checkProduct($sformatf("directed%0d", i), pv[i], 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0]  b;
        logic [7:0]  s;
        logic [15:0] p;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            s = 8'($urandom);
            p = $signed(b) * $signed(s);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
            runSteps(8'($urandom));
            checkProduct($sformatf("random %h*%h", b, s), p, 1'b1);
        end
    endtask

    task automatic test_din_change();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, (i == 7), 1'b1, (i >= 2 && i <= 4) ? 8'h55 : 8'h04);
        checkProduct("din_change", 16'h000C, 1'b1);
    endtask

    task automatic test_reset_midway();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkProduct("reset_midway", 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        runSteps(8'h00);
        checkProduct("after_reset", 16'hFFEB, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b;
        logic [7:0]  s;
        logic [15:0] p;
        logic signed [16:0] v;
        b = 8'($urandom);
        s = 8'($urandom);
        p = $signed(b) * $signed(s);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
        runSteps(8'h00);
        s = 8'($urandom);
        b = p[7:0];
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
        checkProduct("chain_clear", {8'h00, b}, 1'b0);
        p = $signed(b) * $signed(s);
        runSteps(8'h00);
        checkProduct("chain", p, 1'b1);
        // A ninth shift keeps shifting the sign-extended product while Done holds.
        v = $signed({p[15], p}) >>> 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if ({bus.X, bus.Aval, bus.Bval} !== v) begin
            tests_failed++;
            $display("[TB] FAIL extra_shift: got %h expected %h", {bus.X, bus.Aval, bus.Bval}, v);
        end
        tests_run++;
        if (bus.Done !== DONE_EN) begin
            tests_failed++;
            $display("[TB] FAIL extra_shift Done: got %b expected %b", bus.Done, DONE_EN);
        end
    endtask

    task automatic test_load_priority();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h35);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h9C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkProduct("load_only", 16'h9C35, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkProduct("subtract_only", 16'h9C35, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checkProduct("load_subtract", 16'h0035, 1'b0);
        // LoadB wins over A_CLR: S must stay 0x9C from the earlier A_CLR.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
        checkProduct("loadb_priority", 16'h0003, 1'b0);
        runSteps(8'h00);
        checkProduct("priority_product", 16'hFED4, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b1;
        bus.LoadB    = 1'b0;
        bus.A_CLR    = 1'b0;
        bus.Load     = 1'b0;
        bus.Subtract = 1'b0;
        bus.Shift_En = 1'b0;
        bus.Din      = 8'h00;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_directed();
        test_random();
        test_din_change();
        test_reset_midway();
        test_back_to_back();
        test_load_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
